// File: rtl/dtc_trig_decoder.sv
// DTC trigger-line receive decoder: L0/L1 pulses, 8-bit fast commands and
// 72-bit slow-control frames, one sampled bit per dtc_clk, MSB first.
module dtc_trig_decoder #(
  parameter logic [7:0] SLOW_HDR = 8'hE1
) (
  input  logic        dtc_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        trig_bit,
  output logic        l0_stb,
  output logic        l1_stb,
  output logic        fast_stb,
  output logic [7:0]  fast_cmd,
  output logic        slow_stb,
  output logic        slow_rd,
  output logic [31:0] slow_addr,
  output logic [31:0] slow_data,
  output logic        err_stb,
  output logic        busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S11  = 3'd2;
  localparam logic [2:0] CODE = 3'd3;
  localparam logic [2:0] ADDR = 3'd4;
  localparam logic [2:0] DATA = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] addr_q, addr_d;
  logic        l0_d, l1_d, fast_stb_d, slow_stb_d, err_d;
  logic [7:0]  fast_cmd_d;
  logic [31:0] slow_addr_d, slow_data_d;
  logic        slow_rd_d;
  logic [7:0]  code;
  logic        last;
  logic        fast_ok;

  // Valid on the fifth CODE bit: three leading ones plus the shifted bits.
  assign code    = {3'b111, sh_q[3:0], trig_bit};
  assign last    = (cnt_q == 6'd1);
  assign fast_ok = code inside {8'hE2, 8'hE4, 8'hE8, 8'hE9, 8'hEA, 8'hEF};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    l0_d        = 1'b0;
    l1_d        = 1'b0;
    fast_stb_d  = 1'b0;
    slow_stb_d  = 1'b0;
    err_d       = 1'b0;
    fast_cmd_d  = fast_cmd;
    slow_addr_d = slow_addr;
    slow_data_d = slow_data;
    slow_rd_d   = slow_rd;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (trig_bit) state_d = S1;
        S1: begin
          if (trig_bit) begin
            state_d = S11;
          end else begin
            l0_d    = 1'b1;
            state_d = IDLE;
          end
        end
        S11: begin
          if (trig_bit) begin
            state_d = CODE;
            cnt_d   = 6'd5;
          end else begin
            l1_d    = 1'b1;
            state_d = IDLE;
          end
        end
        CODE: begin
          sh_d  = {sh_q[30:0], trig_bit};
          cnt_d = cnt_q - 6'd1;
          if (last) begin
            if (code == SLOW_HDR) begin
              state_d = ADDR;
              cnt_d   = 6'd32;
            end else if (fast_ok) begin
              fast_stb_d = 1'b1;
              fast_cmd_d = code;
              state_d    = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        ADDR: begin
          addr_d = {addr_q[30:0], trig_bit};
          cnt_d  = cnt_q - 6'd1;
          if (last) begin
            state_d = DATA;
            cnt_d   = 6'd32;
          end
        end
        DATA: begin
          sh_d  = {sh_q[30:0], trig_bit};
          cnt_d = cnt_q - 6'd1;
          if (last) begin
            slow_addr_d = addr_q;
            slow_rd_d   = addr_q[31];
            slow_data_d = {sh_q[30:0], trig_bit};
            slow_stb_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      sh_q      <= 32'd0;
      addr_q    <= 32'd0;
      l0_stb    <= 1'b0;
      l1_stb    <= 1'b0;
      fast_stb  <= 1'b0;
      slow_stb  <= 1'b0;
      err_stb   <= 1'b0;
      fast_cmd  <= 8'd0;
      slow_addr <= 32'd0;
      slow_data <= 32'd0;
      slow_rd   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      l0_stb    <= l0_d;
      l1_stb    <= l1_d;
      fast_stb  <= fast_stb_d;
      slow_stb  <= slow_stb_d;
      err_stb   <= err_d;
      fast_cmd  <= fast_cmd_d;
      slow_addr <= slow_addr_d;
      slow_data <= slow_data_d;
      slow_rd   <= slow_rd_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dtc_trig_decoder.sv
// Directed self-checking bench for dtc_trig_decoder.
module tb_dtc_trig_decoder;

  logic        dtc_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        trig_bit;
  logic        l0_stb, l1_stb, fast_stb, slow_stb, err_stb, busy, slow_rd;
  logic [7:0]  fast_cmd;
  logic [31:0] slow_addr, slow_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int l0_cnt = 0, l1_cnt = 0, fast_cnt = 0, slow_cnt = 0, err_cnt = 0, multi = 0;
  int fast_last = 0, fast_prev = 0, start_cyc = 0, slow_cyc = 0;

  dtc_trig_decoder #(.SLOW_HDR(8'hE1)) dut (
    .dtc_clk  (dtc_clk),
    .rst_n    (rst_n),
    .en       (en),
    .trig_bit (trig_bit),
    .l0_stb   (l0_stb),
    .l1_stb   (l1_stb),
    .fast_stb (fast_stb),
    .fast_cmd (fast_cmd),
    .slow_stb (slow_stb),
    .slow_rd  (slow_rd),
    .slow_addr(slow_addr),
    .slow_data(slow_data),
    .err_stb  (err_stb),
    .busy     (busy)
  );

  always #5 dtc_clk = ~dtc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let one rising edge sample it, then observe #1 later.
  task automatic step(input logic b);
    trig_bit = b;
    @(posedge dtc_clk);
    #1;
    cyc++;
    if (l0_stb) l0_cnt++;
    if (l1_stb) l1_cnt++;
    if (err_stb) err_cnt++;
    if (slow_stb) begin
      slow_cnt++;
      slow_cyc = cyc;
    end
    if (fast_stb) begin
      fast_cnt++;
      fast_prev = fast_last;
      fast_last = cyc;
    end
    if ((32'(l0_stb) + 32'(l1_stb) + 32'(fast_stb) + 32'(slow_stb) + 32'(err_stb)) > 1)
      multi++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) step(v[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    trig_bit = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fast_cmd", 32'(fast_cmd), 32'd0);
    chk("rst_slow_addr", slow_addr, 32'd0);
    chk("rst_slow_data", slow_data, 32'd0);
    chk("rst_strobes", {27'd0, l0_stb, l1_stb, fast_stb, slow_stb, err_stb}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge dtc_clk);
    #1;

    // L0 then L1
    step(1'b1);
    chk("l0_busy_rise", 32'(busy), 32'd1);
    chk("l0_early", 32'(l0_stb), 32'd0);
    step(1'b0);
    chk("l0_stb", 32'(l0_stb), 32'd1);
    chk("l0_busy_fall", 32'(busy), 32'd0);
    step(1'b0);
    chk("l0_one_cycle", 32'(l0_stb), 32'd0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("l1_early", 32'(l1_stb), 32'd0);
    chk("l1_busy", 32'(busy), 32'd1);
    step(1'b0);
    chk("l1_stb", 32'(l1_stb), 32'd1);
    chk("l1_busy_fall", 32'(busy), 32'd0);
    step(1'b0);
    chk("l1_one_cycle", 32'(l1_stb), 32'd0);
    chk("l0l1_counts", {l0_cnt[15:0], l1_cnt[15:0]}, {16'd1, 16'd1});

    // Back-to-back fast commands
    send_byte(8'hE2);
    chk("fast1_stb", 32'(fast_stb), 32'd1);
    chk("fast1_cmd", 32'(fast_cmd), 32'hE2);
    send_byte(8'hEF);
    chk("fast2_stb", 32'(fast_stb), 32'd1);
    chk("fast2_cmd", 32'(fast_cmd), 32'hEF);
    chk("fast_spacing", 32'(fast_last - fast_prev), 32'd8);
    chk("fast_count", 32'(fast_cnt), 32'd2);
    chk("fast_no_err", 32'(err_cnt), 32'd0);
    step(1'b0);
    chk("fast_one_cycle", 32'(fast_stb), 32'd0);

    // Slow write
    start_cyc = cyc + 1;
    send_byte(8'hE1);
    send_word(32'h0000_0060);
    send_word(32'h0000_0033);
    chk("slow_w_stb", 32'(slow_stb), 32'd1);
    chk("slow_w_latency", 32'(slow_cyc - start_cyc + 1), 32'd72);
    chk("slow_w_count", 32'(slow_cnt), 32'd1);
    chk("slow_w_addr", slow_addr, 32'h0000_0060);
    chk("slow_w_rd", 32'(slow_rd), 32'd0);
    chk("slow_w_data", slow_data, 32'h0000_0033);
    chk("slow_w_busy", 32'(busy), 32'd0);
    // Slow read, back-to-back
    send_byte(8'hE1);
    send_word(32'h8000_0071);
    send_word(32'h0000_0000);
    chk("slow_r_stb", 32'(slow_stb), 32'd1);
    chk("slow_r_rd", 32'(slow_rd), 32'd1);
    chk("slow_r_addr", slow_addr, 32'h8000_0071);
    chk("slow_r_data", slow_data, 32'h0000_0000);
    step(1'b0);
    chk("slow_one_cycle", 32'(slow_stb), 32'd0);

    // Unknown code, then L0 on the next cycle
    send_byte(8'hE5);
    chk("err_stb", 32'(err_stb), 32'd1);
    chk("err_fast_cmd_held", 32'(fast_cmd), 32'hEF);
    chk("err_no_fast", 32'(fast_cnt), 32'd2);
    step(1'b1);
    chk("err_one_cycle", 32'(err_stb), 32'd0);
    step(1'b0);
    chk("err_then_l0", 32'(l0_stb), 32'd1);

    // Reset at bit 40 of a slow frame
    send_byte(8'hE1);
    for (int i = 31; i >= 1; i--) step(1'(i % 2));
    trig_bit = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_slow_addr", slow_addr, 32'd0);
    chk("abort_slow_data", slow_data, 32'd0);
    chk("abort_fast_cmd", 32'(fast_cmd), 32'd0);
    chk("abort_rd", 32'(slow_rd), 32'd0);
    @(posedge dtc_clk);
    #1;
    trig_bit = 1'b0;
    @(posedge dtc_clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("abort_no_slow", 32'(slow_cnt), 32'd2);
    send_byte(8'hE1);
    send_word(32'h0000_0ABC);
    send_word(32'hDEAD_BEEF);
    chk("post_abort_stb", 32'(slow_stb), 32'd1);
    chk("post_abort_addr", slow_addr, 32'h0000_0ABC);
    chk("post_abort_data", slow_data, 32'hDEAD_BEEF);
    chk("post_abort_rd", 32'(slow_rd), 32'd0);

    // Enable dropped at bit 5 of a fast command
    send_byte(8'hE4);
    chk("en_pre_cmd", 32'(fast_cmd), 32'hE4);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    en = 1'b0;
    step(1'b1);
    chk("en_low_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("en_no_fast", 32'(fast_cnt), 32'd3);
    chk("en_fast_cmd_held", 32'(fast_cmd), 32'hE4);
    chk("en_no_err", 32'(err_cnt), 32'd1);
    send_byte(8'hE9);
    chk("en_next_stb", 32'(fast_stb), 32'd1);
    chk("en_next_cmd", 32'(fast_cmd), 32'hE9);
    step(1'b0);
    chk("strobes_exclusive", 32'(multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
